// File: rtl/demux2_16bit_buf_if.sv
`default_nettype none
// ============================================================================
// Module  : demux2_16bit_buf_if
// Brief   : Producer stream and two consumer channels of the 1:2 demux.
// Rev     : 1.0  initial release
// ============================================================================
interface demux2_16bit_buf_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [1:0]       cnt0;
    logic [1:0]       cnt1;

    modport slave (
        input  in_data, in_sel, in_valid, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
    );

    modport master (
        output in_data, in_sel, in_valid, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
    );
endinterface
`default_nettype wire

// File: rtl/demux2_16bit_buf.sv
`default_nettype none
// ============================================================================
// Module  : demux2_16bit_buf
// Brief   : Registered 1:2 demux, 2-entry FIFO per output channel.
//           Optional DEMUX2_ENABLE_PORT_EN adds an input-accept enable port.
// Rev     : 1.0  initial release
// ============================================================================
module demux2_16bit_buf #(
    parameter int WIDTH = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
`ifdef DEMUX2_ENABLE_PORT_EN
    input  wire logic                 en,
`endif
    demux2_16bit_buf_if.slave         bus
);

    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_FULL  = 2'd2;

    logic             w_en;
    logic             w_accept;
    logic [1:0]       w_cnt   [2];
    logic [WIDTH-1:0] w_head  [2];
    logic             w_oready[2];

`ifdef DEMUX2_ENABLE_PORT_EN
    assign w_en = en;
`else
    assign w_en = 1'b1;
`endif

    assign w_oready[0] = bus.out0_ready;
    assign w_oready[1] = bus.out1_ready;

    // A full destination refuses input even if it pops this cycle.
    assign bus.in_ready = w_en & ((bus.in_sel ? w_cnt[1] : w_cnt[0]) != c_FULL);
    assign w_accept     = bus.in_valid & bus.in_ready;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_ch
            localparam logic c_SEL = (g == 1);

            logic [WIDTH-1:0] r_mem [2];
            logic             r_wptr;
            logic             r_rptr;
            logic [1:0]       r_cnt;
            logic [WIDTH-1:0] r_head;
            logic             w_push;
            logic             w_pop;

            assign w_push = w_accept & (bus.in_sel == c_SEL);
            assign w_pop  = (r_cnt != c_EMPTY) & w_oready[g];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_mem[0] <= '0;
                    r_mem[1] <= '0;
                    r_wptr   <= 1'b0;
                    r_rptr   <= 1'b0;
                    r_cnt    <= c_EMPTY;
                    r_head   <= '0;
                end else begin
                    if (w_push) begin
                        r_mem[r_wptr] <= bus.in_data;
                        r_wptr        <= ~r_wptr;
                    end
                    if (w_pop) begin
                        r_rptr <= ~r_rptr;
                    end

                    case ({w_push, w_pop})
                        2'b10:   r_cnt <= r_cnt + 2'd1;
                        2'b01:   r_cnt <= r_cnt - 2'd1;
                        default: r_cnt <= r_cnt;
                    endcase

                    // Head register mirrors the next FIFO head; holds when drained.
                    if (w_push && (r_cnt == c_EMPTY || (w_pop && r_cnt == c_ONE))) begin
                        r_head <= bus.in_data;
                    end else if (w_pop && r_cnt == c_FULL) begin
                        r_head <= r_mem[~r_rptr];
                    end
                end
            end

            assign w_cnt[g]  = r_cnt;
            assign w_head[g] = r_head;
        end
    endgenerate

    assign bus.cnt0       = w_cnt[0];
    assign bus.cnt1       = w_cnt[1];
    assign bus.out0_valid = (w_cnt[0] != c_EMPTY);
    assign bus.out1_valid = (w_cnt[1] != c_EMPTY);
    assign bus.out0_data  = w_head[0];
    assign bus.out1_data  = w_head[1];

endmodule
`default_nettype wire

// File: tb/tb_demux2_16bit_buf.sv
`default_nettype none
// ============================================================================
// Module  : tb_demux2_16bit_buf
// Brief   : Directed self-checking bench for demux2_16bit_buf.
// Rev     : 1.0  initial release
// ============================================================================
module tb_demux2_16bit_buf;

    logic clk;
    logic rst;
`ifdef DEMUX2_ENABLE_PORT_EN
    logic en;
`endif
    int   n_checks;
    int   n_errors;

    demux2_16bit_buf_if #(.WIDTH(16)) bus ();

    demux2_16bit_buf #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
`ifdef DEMUX2_ENABLE_PORT_EN
        .en  (en),
`endif
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [15:0] d);
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_data  = d;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
`ifdef DEMUX2_ENABLE_PORT_EN
        en             = 1'b1;
`endif
        drive(1'b0, 1'b0, 16'h0000);
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        step();
        rst = 1'b0;
        check("rst_cnt0", 32'(bus.cnt0), 32'd0);
        check("rst_v0", 32'(bus.out0_valid), 32'd0);

        // Fill channel 0, then reset asynchronously mid-cycle
        drive(1'b1, 1'b0, 16'hDEAD); step();
        drive(1'b1, 1'b0, 16'hBEEF); step();
        drive(1'b0, 1'b0, 16'h0000);
        check("fill_cnt0", 32'(bus.cnt0), 32'd2);
        check("fill_d0", 32'(bus.out0_data), 32'hDEAD);
        #2 rst = 1'b1;
        #1;
        check("arst_cnt0", 32'(bus.cnt0), 32'd0);
        check("arst_cnt1", 32'(bus.cnt1), 32'd0);
        check("arst_v0", 32'(bus.out0_valid), 32'd0);
        check("arst_v1", 32'(bus.out1_valid), 32'd0);
        check("arst_d0", 32'(bus.out0_data), 32'h0);
        rst = 1'b0;
        step();

        // Single push, one-edge latency
        drive(1'b1, 1'b0, 16'hA5A5); #1;
        check("a5_rdy", 32'(bus.in_ready), 32'd1);
        step();
        drive(1'b0, 1'b0, 16'h0000);
        check("a5_v0", 32'(bus.out0_valid), 32'd1);
        check("a5_d0", 32'(bus.out0_data), 32'hA5A5);
        check("a5_cnt0", 32'(bus.cnt0), 32'd1);
        check("a5_v1", 32'(bus.out1_valid), 32'd0);

        // Channel 1 fill, backpressure, ordered drain
        drive(1'b1, 1'b1, 16'h1111); step();
        drive(1'b1, 1'b1, 16'h2222); step();
        drive(1'b1, 1'b1, 16'h3333); #1;
        check("c1_full_rdy", 32'(bus.in_ready), 32'd0);
        check("c1_full_cnt", 32'(bus.cnt1), 32'd2);
        check("c1_head0", 32'(bus.out1_data), 32'h1111);
        step();
        check("c1_hold_cnt", 32'(bus.cnt1), 32'd2);
        bus.out1_ready = 1'b1; #1;
        check("c1_pop_rdy", 32'(bus.in_ready), 32'd0);
        step();
        check("c1_cnt_a", 32'(bus.cnt1), 32'd1);
        check("c1_head1", 32'(bus.out1_data), 32'h2222);
        check("c1_rdy_one", 32'(bus.in_ready), 32'd1);
        step();
        drive(1'b0, 1'b0, 16'h0000);
        check("c1_cnt_b", 32'(bus.cnt1), 32'd1);
        check("c1_head2", 32'(bus.out1_data), 32'h3333);
        step();
        bus.out1_ready = 1'b0;
        check("c1_empty", 32'(bus.cnt1), 32'd0);
        check("c1_empty_v", 32'(bus.out1_valid), 32'd0);
        check("c1_hold_d", 32'(bus.out1_data), 32'h3333);

        // Full channel 0 does not block channel 1
        drive(1'b1, 1'b0, 16'h5A5A); step();
        drive(1'b1, 1'b0, 16'hC0DE); #1;
        check("c0_full_rdy", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 1'b1, 16'hBEEF); #1;
        check("x_rdy", 32'(bus.in_ready), 32'd1);
        step();
        drive(1'b0, 1'b0, 16'h0000);
        check("x_d1", 32'(bus.out1_data), 32'hBEEF);
        check("x_v1", 32'(bus.out1_valid), 32'd1);
        check("x_cnt0", 32'(bus.cnt0), 32'd2);
        check("x_d0", 32'(bus.out0_data), 32'hA5A5);

        // Drain both channels
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        step();
        check("dr_cnt0", 32'(bus.cnt0), 32'd1);
        check("dr_d0", 32'(bus.out0_data), 32'h5A5A);
        check("dr_cnt1", 32'(bus.cnt1), 32'd0);
        step();
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        check("dr_cnt0_b", 32'(bus.cnt0), 32'd0);
        check("dr_hold_d0", 32'(bus.out0_data), 32'h5A5A);

        // Simultaneous push and pop while holding one word
        drive(1'b1, 1'b0, 16'h0001); step();
        check("pp_cnt_a", 32'(bus.cnt0), 32'd1);
        check("pp_d_a", 32'(bus.out0_data), 32'h0001);
        drive(1'b1, 1'b0, 16'h0002);
        bus.out0_ready = 1'b1; #1;
        check("pp_rdy", 32'(bus.in_ready), 32'd1);
        step();
        drive(1'b0, 1'b0, 16'h0000);
        check("pp_cnt_b", 32'(bus.cnt0), 32'd1);
        check("pp_d_b", 32'(bus.out0_data), 32'h0002);
        step();
        check("pp_cnt_c", 32'(bus.cnt0), 32'd0);
        step();
        check("pop_empty_cnt", 32'(bus.cnt0), 32'd0);
        check("pop_empty_d", 32'(bus.out0_data), 32'h0002);
        bus.out0_ready = 1'b0;

`ifdef DEMUX2_ENABLE_PORT_EN
        en = 1'b0;
        drive(1'b1, 1'b0, 16'h7777); #1;
        check("en0_rdy", 32'(bus.in_ready), 32'd0);
        step();
        check("en0_cnt", 32'(bus.cnt0), 32'd0);
        en = 1'b1; #1;
        check("en1_rdy", 32'(bus.in_ready), 32'd1);
        step();
        drive(1'b0, 1'b0, 16'h0000);
        check("en1_cnt", 32'(bus.cnt0), 32'd1);
        check("en1_d", 32'(bus.out0_data), 32'h7777);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux2_16bit_buf.md
Name: demux2_16bit_buf

Overview:
- Registered 1-to-2 demultiplexer; the inverse of the datapath 2:1 select.
- Takes a single WIDTH-bit input stream with a per-word select and steers each accepted word into one of two output channels.
- Each output channel has a 2-entry FIFO and a valid/ready handshake.
- Sits between a producer stage and two consumers, e.g. ALU result routed to register file vs. memory write path.

Parameters:
- WIDTH, 16, data width of input and both output channels.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  input word.
- in_sel  input  1  destination: 0 -> channel 0, 1 -> channel 1; sampled only when in_valid=1.
- in_valid  input  1  producer has a word on in_data/in_sel.
- in_ready  output  1  block accepts the word this cycle.
- out0_data  output  WIDTH  channel 0 head word.
- out0_valid  output  1  channel 0 FIFO non-empty.
- out0_ready  input  1  channel 0 consumer takes head word.
- out1_data  output  WIDTH  channel 1 head word.
- out1_valid  output  1  channel 1 FIFO non-empty.
- out1_ready  input  1  channel 1 consumer takes head word.
- cnt0  output  2  channel 0 occupancy (0..2).
- cnt1  output  2  channel 1 occupancy (0..2).

Behaviour:
- Reset (async, rst=1): both FIFOs flushed; cnt0=cnt1=0; out0_valid=out1_valid=0; out0_data=out1_data=0. Reset asserted mid-transfer discards all stored words immediately; there is no partial state.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Channel N pop = outN_valid & outN_ready.
- in_ready is combinational: (in_sel ? cnt1 : cnt0) != 2. When in_valid=0, in_ready is don't-care and nothing is accepted.
- Per-channel state is a count: EMPTY(0), ONE(1), FULL(2).
  - push only: count+1.
  - pop only: count-1.
  - push+pop together in ONE: count stays 1; the head is replaced by the new word on the next edge.
  - push+pop together in EMPTY: impossible, because out_valid=0.
  - FULL with pop: in_ready stays 0 that cycle. There is no same-cycle pass-through; the slot frees on the next edge.
- Latency: a word accepted on edge k is visible on outN_data with outN_valid=1 after edge k (registered output), provided the FIFO was empty.
- Ordering: strict FIFO order within each channel. There is no ordering guarantee between channels.
- outN_data holds the head word stable while outN_valid=1 and outN_ready=0.
- When EMPTY, outN_data holds its last value and is 0 after reset.
- Channels pop independently; a full channel never blocks words destined to the other channel.
- Pop on an empty channel (outN_ready=1, outN_valid=0) has no effect.
- Storage is a 2-entry register array per channel with 1-bit read/write pointers that wrap 1 -> 0.

Optional Feature:
- Macro DEMUX2_ENABLE_PORT_EN.
- When defined: extra input port en (1 bit), placed after rst.
  - en=0 forces in_ready=0 (no accepts). Outputs still drain normally.
  - en=1 gives normal behaviour.
- When undefined: no en port; the block behaves as if en=1.

Test Plan:
- Reset with rst=1 while a word is stored (cnt0=2) -> immediately cnt0=cnt1=0, out0_valid=out1_valid=0, out0_data=0.
- Push 0xA5A5 sel=0 with out0_ready=0 -> next cycle out0_valid=1, out0_data=0xA5A5, cnt0=1, out1_valid=0.
- Push 0x1111, 0x2222, 0x3333 to sel=1 with out1_ready=0 -> first two accepted, third sees in_ready=0 and cnt1=2. Then out1_ready=1 yields 0x1111, then 0x2222, then 0x3333 is accepted.
- Channel 0 full (cnt0=2); push 0xBEEF sel=1 -> accepted; out1_data=0xBEEF next cycle; cnt0 unchanged.
- cnt0=1 holding 0x0001; same cycle push 0x0002 sel=0 and out0_ready=1 -> cnt0 stays 1, out0_data=0x0002 next cycle.
- With DEMUX2_ENABLE_PORT_EN defined, en=0, in_valid=1 -> in_ready=0 and no count change. Setting en=1 accepts the word next edge.
